reverse_stream_checker: RTL and testbench

- Downstream sink for the bit-reversing valid/ready stage in the sm_test example; consumes its output stream and checks it.
- Compares each accepted word against the bit-reversal of an internal expected counter sequence.
- Injects periodic backpressure to exercise the upstream stall path.
- Reports done, pass, saturating error count and index of first mismatch for the test harness.

---
 rtl/reverse_stream_checker.sv | 209 ++++++++++++++++++++
 tb/tb_reverse_stream_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reverse_stream_checker.sv
// reverse_stream_checker
//   Sink for the bit-reversing valid/ready stage. It accepts NUM_WORDS words
//   and checks each one against bitrev(SEED + n). It drops o_ready for one
//   cycle in every STALL_PERIOD while running, so the upstream stall path is
//   exercised. It reports done, pass, a saturating error count and the index
//   of the first bad word.
//
//   Optional feature: define REVERSE_STREAM_CHECKER_TIMEOUT_EN to build a
//   watchdog. The watchdog ends the run, with timeout=1, after TIMEOUT_CYCLES
//   RUN cycles without a transfer. Without the macro, timeout is constant 0.
//
// Ports
//   clk, reset     clock; asynchronous active-high reset
//   start          one-cycle pulse; starts a run from IDLE or DONE
//   i_valid        upstream word valid
//   o_ready        sink ready; a word transfers on i_valid && o_ready
//   i_data         upstream word, expected to be bit-reversed
//   done           run finished; held until the next start
//   pass           meaningful while done: no errors and no timeout
//   err_count      mismatches in this run; saturates at all-ones
//   first_err_idx  index of the first mismatching word; all-ones if none
//   timeout        watchdog fired

module reverse_stream_checker #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned NUM_WORDS      = 16,
  parameter int unsigned SEED           = 0,
  parameter int unsigned STALL_PERIOD   = 4,
  parameter int unsigned ERR_W          = 8,
  parameter int unsigned IDX_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [IDX_W-1:0] first_err_idx,
  output logic             timeout
);

  localparam bit                STALL_EN   = (STALL_PERIOD >= 2);
  localparam int unsigned       STALL_W    = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_EN ? STALL_PERIOD - 1 : 0);
  localparam logic [WIDTH-1:0]  SEED_W     = WIDTH'(SEED);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   expected;
  logic [WIDTH-1:0]   ref_word;
  logic [STALL_W-1:0] stall_cnt;
  logic               stall_slot;
  logic               xfer;
  logic               mismatch;
  logic               last_xfer;
  logic               enter_run;
  logic               wd_fire;

  // ---------------------------------------------------------------------
  // Handshake and compare
  // ---------------------------------------------------------------------
  assign stall_slot = STALL_EN && (stall_cnt == STALL_LAST);

  // o_ready depends only on registered state. There is no path from i_valid.
  assign o_ready   = (state == S_RUN) && !stall_slot;
  assign xfer      = i_valid && o_ready;
  assign mismatch  = (i_data != ref_word);
  assign last_xfer = xfer && (idx == LAST_IDX);

  always_comb begin
    ref_word = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ref_word[i] = expected[WIDTH-1-i];
    end
  end

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
`ifdef REVERSE_STREAM_CHECKER_TIMEOUT_EN
  localparam int unsigned     WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [WD_W-1:0] wd_cnt;

  // The watchdog fires on the edge that would bring the idle count up to
  // TIMEOUT_CYCLES.
  assign wd_fire = (state == S_RUN) && !xfer && (wd_cnt == WD_LAST);
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign wd_fire            = 1'b0;
  assign timeout            = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    enter_run = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          enter_run = 1'b1;
        end
      end
      S_RUN: begin
        if (last_xfer || wd_fire) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Run datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      expected      <= '0;
      stall_cnt     <= '0;
      err_count     <= '0;
      first_err_idx <= '1;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else if (enter_run) begin
      idx           <= '0;
      expected      <= SEED_W;
      stall_cnt     <= '0;
      err_count     <= '0;
      first_err_idx <= '1;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else if (state == S_RUN) begin
      if (stall_slot || !STALL_EN) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 1'b1;
      end

      if (xfer) begin
        if (mismatch) begin
          if (!(&err_count)) begin
            err_count <= err_count + 1'b1;
          end
          if (&first_err_idx) begin
            first_err_idx <= idx;
          end
        end
        idx      <= idx + 1'b1;
        expected <= expected + 1'b1;
        if (last_xfer) begin
          // The last word's own compare result counts toward pass.
          done <= 1'b1;
          pass <= (err_count == '0) && !mismatch;
        end
      end else if (wd_fire) begin
        done <= 1'b1;
        pass <= 1'b0;
      end
    end
  end

`ifdef REVERSE_STREAM_CHECKER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (enter_run) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (state == S_RUN) begin
      if (xfer) begin
        wd_cnt <= '0;
      end else if (wd_fire) begin
        timeout <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reverse_stream_checker.sv
// Testbench for reverse_stream_checker.
// There are two instances. u_dut0 uses the default setup: 16 words, seed 0,
// stall every 4th cycle. u_dut1 uses 4 words, seed FE, stall every 3rd cycle
// and a 2-bit error count. This covers wrap-around and error-count
// saturation. A reference model predicts o_ready and the results of each
// run. It works from the word index, the cycle count and plain arithmetic.

module tb_reverse_stream_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ready0, ready1, done0, done1, pass0, pass1, tmo0, tmo1;
  logic [7:0] err0, first0, first1;
  logic [1:0] err1;

  logic       sel = 1'b0;
  logic       obs_ready, obs_done, obs_pass, obs_tmo;
  logic [7:0] obs_err, obs_first;

  int n_tests = 0;
  int n_fail  = 0;

  int m_nw, m_seed, m_p, m_errmax;
  int m_idx, m_errs, m_first, m_c, m_idle;

  always #5 clk = ~clk;

  reverse_stream_checker #(
    .WIDTH(8), .NUM_WORDS(16), .SEED(0), .STALL_PERIOD(4),
    .ERR_W(8), .IDX_W(8), .TIMEOUT_CYCLES(10)
  ) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .i_valid(valid0),
    .o_ready(ready0), .i_data(data0), .done(done0), .pass(pass0),
    .err_count(err0), .first_err_idx(first0), .timeout(tmo0)
  );

  reverse_stream_checker #(
    .WIDTH(8), .NUM_WORDS(4), .SEED(8'hFE), .STALL_PERIOD(3),
    .ERR_W(2), .IDX_W(8), .TIMEOUT_CYCLES(10)
  ) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .i_valid(valid1),
    .o_ready(ready1), .i_data(data1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_idx(first1), .timeout(tmo1)
  );

  assign obs_ready = sel ? ready1 : ready0;
  assign obs_done  = sel ? done1 : done0;
  assign obs_pass  = sel ? pass1 : pass0;
  assign obs_tmo   = sel ? tmo1 : tmo0;
  assign obs_err   = sel ? {6'b0, err1} : err0;
  assign obs_first = sel ? first1 : first0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] x);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = x[7-i];
    return b;
  endfunction

  // Cycle m_c of a run has o_ready low in its last slot of every m_p cycles.
  function automatic bit model_ready();
    return (m_c % m_p) != (m_p - 1);
  endfunction

  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    if (sel) begin
      start1 = s; valid1 = v; data1 = d;
    end else begin
      start0 = s; valid0 = v; data0 = d;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, obs_ready, 0);
    check({tag, "_done"}, obs_done, 0);
    check({tag, "_pass"}, obs_pass, 0);
    check({tag, "_err"}, obs_err, 0);
    check({tag, "_first"}, obs_first, 8'hFF);
    check({tag, "_tmo"}, obs_tmo, 0);
  endtask

  // One run on the selected instance. It stops early once stop_after words
  // have transferred (pass -1 to run to completion).
  task automatic do_run(input int err_pct, input int bad_idx, input int stop_after,
                        input bit mid_start);
    logic [7:0] d, r;
    logic       v, s;
    bit         pulsed;
    int         budget;
    m_nw     = sel ? 4 : 16;
    m_seed   = sel ? 8'hFE : 0;
    m_p      = sel ? 3 : 4;
    m_errmax = sel ? 3 : 255;
    m_idx = 0; m_errs = 0; m_first = 255; m_c = 0; m_idle = 0;
    pulsed = 0; budget = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 8'h00);
    @(posedge clk);
    while (m_idx < m_nw && m_idx != stop_after && budget < 500) begin
      @(negedge clk);
      check("ready", obs_ready, model_ready());
      check("err_count", obs_err, m_errs);
      check("first_idx", obs_first, m_first);
      check("done_low", obs_done, 0);
      v = (m_idle >= 4) || ($urandom_range(0, 3) != 0);
      r = bitrev(8'(m_seed + m_idx));
      d = r;
      if (m_idx == bad_idx) d = 8'h00;
      else if ($urandom_range(1, 100) <= err_pct) d = r ^ 8'($urandom_range(1, 255));
      s = mid_start && (m_idx == 3) && !pulsed;
      if (s) pulsed = 1;
      drive(s, v, d);
      @(posedge clk);
      if (v && model_ready()) begin
        if (d != r) begin
          if (m_errs < m_errmax) m_errs++;
          if (m_first == 255) m_first = m_idx;
        end
        m_idx++;
        m_idle = 0;
      end else begin
        m_idle++;
      end
      m_c++;
      budget++;
    end
    if (budget >= 500) check("run_budget", budget, 0);
    if (m_idx == m_nw) begin
      @(negedge clk);
      check("done", obs_done, 1);
      check("pass", obs_pass, m_errs == 0);
      check("final_err", obs_err, m_errs);
      check("final_first", obs_first, m_first);
      check("final_ready", obs_ready, 0);
      check("final_tmo", obs_tmo, 0);
      // Words offered while DONE must be ignored.
      drive(1'b0, 1'b1, 8'h5A);
      repeat (2) @(negedge clk);
      check("done_hold", obs_done, 1);
      check("done_err_hold", obs_err, m_errs);
      check("done_first_hold", obs_first, m_first);
      drive(1'b0, 1'b0, 8'h00);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    sel = 0; #1 check_idle_outputs("rst0");
    sel = 1; #1 check_idle_outputs("rst1");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    sel = 0; #1 check_idle_outputs("idle0");

    // Clean runs, then a single corrupted word 5 (00 instead of A0).
    sel = 0;
    do_run(0, -1, -1, 0);
    do_run(0, 5, -1, 0);
    // Every word wrong on the 2-bit counter instance; then a clean wrap run.
    sel = 1;
    do_run(100, -1, -1, 0);
    do_run(0, -1, -1, 0);
    // Random error mixes on both instances.
    sel = 0;
    repeat (3) do_run(30, -1, -1, 0);
    sel = 1;
    repeat (3) do_run(40, -1, -1, 0);

    // A start pulse during RUN must be ignored; reset after 7 words.
    sel = 0;
    do_run(50, -1, 7, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(negedge clk);
    reset = 1'b0;
    do_run(0, -1, -1, 0);

    // Upstream goes quiet after word 3.
    do_run(0, -1, 4, 0);
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
`ifdef REVERSE_STREAM_CHECKER_TIMEOUT_EN
      check("wd_timeout", obs_tmo, k >= 10);
      check("wd_done", obs_done, k >= 10);
      check("wd_pass", obs_pass, 0);
      if (k >= 10) check("wd_ready", obs_ready, 0);
      else check("wd_ready", obs_ready, model_ready());
`else
      check("nowd_timeout", obs_tmo, 0);
      check("nowd_done", obs_done, 0);
      check("nowd_ready", obs_ready, model_ready());
`endif
      check("wd_err", obs_err, 0);
      check("wd_first", obs_first, 8'hFF);
      drive(1'b0, 1'b0, 8'h00);
      m_c++;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
